sap_ram: RTL and testbench

- 16 x 8 RAM with a built-in 4-bit memory address register (MAR) for the SAP-style 8-bit computer.
- The MAR loads from the address DIP switches or from the low nibble of the bus.
- Write data comes from the data DIP switches (manual programming) or from the bus (run mode, RAM-in control).
- Read data of the addressed word drives the bus output when output-enabled.

---
 rtl/sap_ram.sv | 78 +++++++
 tb/tb_sap_ram.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sap_ram.sv
// 16x8 RAM with a built-in memory address register for the SAP-style 8-bit computer.
// Optional `RAM_RESET_CLEAR_EN: rst_n also clears every word asynchronously.
module sap_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dipswitch_data,
  input  logic [ADDR_WIDTH-1:0] dipswitch_addr,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  addr_select,
  input  logic                  prog_mode,
  input  logic                  bus_enable_n,
  input  logic                  write_enable_n,
  input  logic                  control_signal,
  input  logic                  load_mar_reg_n,
  input  logic                  clear_mar_reg,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic [ADDR_WIDTH-1:0] mar_out
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  // Clear has priority over load; the bus only contributes its low nibble.
  always_comb begin
    mar_d = mar_q;
    if (clear_mar_reg) begin
      mar_d = '0;
    end else if (!load_mar_reg_n) begin
      mar_d = addr_select ? bus_in[ADDR_WIDTH-1:0] : dipswitch_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q <= '0;
    end else begin
      mar_q <= mar_d;
    end
  end

  // Run-mode writes need the RAM-in control; manual writes only need the strobe.
  always_comb begin
    wr_en   = !write_enable_n && (!prog_mode || control_signal);
    wr_data = prog_mode ? bus_in : dipswitch_data;
  end

`ifdef RAM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[mar_q] <= wr_data;
    end
  end
`else
  // No array reset: rst_n only blocks a write that lands while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && wr_en) begin
      mem_q[mar_q] <= wr_data;
    end
  end
`endif

  always_comb begin
    bus_out = bus_enable_n ? '0 : mem_q[mar_q];
    mar_out = mar_q;
  end

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: directed steps then random traffic against a word-array model.
module tb_sap_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dipswitch_data, bus_in, bus_out;
  logic [3:0] dipswitch_addr, mar_out;
  logic       addr_select, prog_mode, bus_enable_n, write_enable_n;
  logic       control_signal, load_mar_reg_n, clear_mar_reg;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [16];
  bit         m_val [16];
  int         m_mar;

  sap_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dipswitch_data (dipswitch_data),
    .dipswitch_addr (dipswitch_addr),
    .bus_in         (bus_in),
    .addr_select    (addr_select),
    .prog_mode      (prog_mode),
    .bus_enable_n   (bus_enable_n),
    .write_enable_n (write_enable_n),
    .control_signal (control_signal),
    .load_mar_reg_n (load_mar_reg_n),
    .clear_mar_reg  (clear_mar_reg),
    .bus_out        (bus_out),
    .mar_out        (mar_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mar = 0;
`ifdef RAM_RESET_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 8'h00;
      m_val[i] = 1'b1;
    end
`endif
  endtask

  // Inputs as seen at the rising edge: write at the old address, then move the MAR.
  task automatic model_edge();
    if (!write_enable_n && (!prog_mode || control_signal)) begin
      m_mem[m_mar] = prog_mode ? bus_in : dipswitch_data;
      m_val[m_mar] = 1'b1;
    end
    if (clear_mar_reg) m_mar = 0;
    else if (!load_mar_reg_n) m_mar = addr_select ? int'(bus_in % 16) : int'(dipswitch_addr);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":mar"}, {4'h0, mar_out}, 8'(m_mar));
    if (bus_enable_n) chk({tag, ":bus_off"}, bus_out, 8'h00);
    else if (m_val[m_mar]) chk({tag, ":bus_rd"}, bus_out, m_mem[m_mar]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    write_enable_n = 1'b1;
    load_mar_reg_n = 1'b1;
    clear_mar_reg  = 1'b0;
    control_signal = 1'b0;
    prog_mode      = 1'b0;
    addr_select    = 1'b0;
    bus_enable_n   = 1'b0;
  endtask

  task automatic load_dip(input logic [3:0] a, input string tag);
    idle();
    dipswitch_addr = a;
    load_mar_reg_n = 1'b0;
    tick(tag);
  endtask

  task automatic write_dip(input logic [7:0] d, input string tag);
    idle();
    dipswitch_data = d;
    write_enable_n = 1'b0;
    tick(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    dipswitch_data = 8'h00;
    dipswitch_addr = 4'h0;
    bus_in         = 8'h00;
    idle();

    // Asynchronous reset, checked before any clock edge
    rst_n = 1'b0;
    model_reset();
    #2;
    check_state("reset");
    chk("reset_mar", {4'h0, mar_out}, 8'h00);
    tick("reset_hold");
    rst_n = 1'b1;
    #2;

`ifdef RAM_RESET_CLEAR_EN
    for (int a = 0; a < 16; a++) begin
      load_dip(4'(a), "clr_scan");
      chk("clr_zero", bus_out, 8'h00);
    end
`endif

    // MAR from switches, then from the bus low nibble
    load_dip(4'hA, "mar_dip");
    chk("mar_dip_lit", {4'h0, mar_out}, 8'h0A);
    idle();
    addr_select    = 1'b1;
    bus_in         = 8'hF7;
    load_mar_reg_n = 1'b0;
    tick("mar_bus");
    chk("mar_bus_lit", {4'h0, mar_out}, 8'h07);

    // Manual write at MAR 7
    write_dip(8'hCF, "man_wr");
    chk("man_wr_lit", bus_out, 8'hCF);

    // Run-mode write, then a blocked one
    idle();
    prog_mode = 1'b1; control_signal = 1'b1; bus_in = 8'hF7; write_enable_n = 1'b0;
    tick("run_wr");
    chk("run_wr_lit", bus_out, 8'hF7);
    idle();
    prog_mode = 1'b1; control_signal = 1'b0; bus_in = 8'h12; write_enable_n = 1'b0;
    tick("run_blk");
    chk("run_blk_lit", bus_out, 8'hF7);

    // Output disable and clear-beats-load
    idle();
    bus_enable_n = 1'b1;
    #1;
    chk("bus_dis", bus_out, 8'h00);
    idle();
    clear_mar_reg = 1'b1; load_mar_reg_n = 1'b0; dipswitch_addr = 4'h9;
    tick("clr_win");
    chk("clr_win_lit", {4'h0, mar_out}, 8'h00);

    // Simultaneous load and write: write goes to the old address
    load_dip(4'h5, "pre5");
    write_dip(8'h55, "pre5_wr");
    load_dip(4'h3, "to3");
    idle();
    dipswitch_addr = 4'h5; load_mar_reg_n = 1'b0; dipswitch_data = 8'hAA; write_enable_n = 1'b0;
    tick("ld_wr");
    chk("ld_wr_mar", {4'h0, mar_out}, 8'h05);
    chk("ld_wr_m5", bus_out, 8'h55);
    load_dip(4'h3, "rd3");
    chk("ld_wr_m3", bus_out, 8'hAA);

    // Reset mid-operation with a write pending: the write must not land
    load_dip(4'h0, "to0");
    write_dip(8'h11, "pre0_wr");
    load_dip(4'h5, "to5");
    idle();
    dipswitch_data = 8'h99; write_enable_n = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("midrst");
    tick("midrst_edge");
    rst_n = 1'b1;
    idle();
    #1;
    check_state("midrst_rd0");
`ifdef RAM_RESET_CLEAR_EN
    chk("midrst_m0", bus_out, 8'h00);
`else
    chk("midrst_m0", bus_out, 8'h11);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      dipswitch_data = 8'($urandom);
      dipswitch_addr = 4'($urandom);
      bus_in         = 8'($urandom);
      addr_select    = 1'($urandom);
      prog_mode      = 1'($urandom);
      control_signal = 1'($urandom);
      write_enable_n = 1'($urandom);
      load_mar_reg_n = 1'($urandom);
      clear_mar_reg  = ($urandom_range(7) == 0);
      bus_enable_n   = ($urandom_range(3) == 0);
      rst_n          = ($urandom_range(39) != 0);
      if (!rst_n) begin
        model_reset();
        #1;
        check_state("rnd_rst");
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
